sddr_init_seq: RTL

//  Power-up sequencer for the DDR3 controller; sits directly upstream of it on the cpu_clock_i side.

---
 rtl/sddr_init_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sddr_init_seq.sv
// DDR3 power-up sequencer: walks the controller's register port through reset release,
// CKE, PRECHARGE-ALL and ZQCL with timed waits, then hands the bus to the controller.
module sddr_init_seq #(
    parameter int          T_RESET     = 20000,
    parameter int          T_CKE       = 50000,
    parameter int          T_XPR       = 30,
    parameter int          T_RP        = 2,
    parameter int          T_ZQINIT    = 52,
    parameter logic [31:0] FINAL_STATE = 32'h0000_002F
) (
    input  logic        cpu_clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [3:0]  step_o,
    output logic        ctrl_cmd_valid,
    output logic [15:0] ctrl_cmd_address,
    output logic [31:0] ctrl_cmd_data,
    output logic        ctrl_cmd_write,
    input  logic        ctrl_cmd_ack
);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_W_RST0   = 4'd1;
    localparam logic [3:0] ST_WAIT_RST = 4'd2;
    localparam logic [3:0] ST_W_RST1   = 4'd3;
    localparam logic [3:0] ST_WAIT_CKE = 4'd4;
    localparam logic [3:0] ST_W_CKE    = 4'd5;
    localparam logic [3:0] ST_WAIT_XPR = 4'd6;
    localparam logic [3:0] ST_W_PREA   = 4'd7;
    localparam logic [3:0] ST_WAIT_RP  = 4'd8;
    localparam logic [3:0] ST_W_ZQCL   = 4'd9;
    localparam logic [3:0] ST_WAIT_ZQ  = 4'd10;
    localparam logic [3:0] ST_W_FIN    = 4'd11;
    localparam logic [3:0] ST_DONE     = 4'd12;

    function automatic int max2(input int a, input int b);
        if (a > b) begin
            max2 = a;
        end else begin
            max2 = b;
        end
    endfunction

    localparam int T_MAX = max2(max2(max2(T_RESET, T_CKE), max2(T_XPR, T_RP)), T_ZQINIT);
    localparam int CW    = $clog2(T_MAX) + 1;

    // Each write state is immediately followed by its wait state, so the load value keys off the write.
    function automatic logic [CW-1:0] wait_load(input logic [3:0] st);
        case (st)
            ST_W_RST0: wait_load = CW'(T_RESET - 1);
            ST_W_RST1: wait_load = CW'(T_CKE - 1);
            ST_W_CKE:  wait_load = CW'(T_XPR - 1);
            ST_W_PREA: wait_load = CW'(T_RP - 1);
            ST_W_ZQCL: wait_load = CW'(T_ZQINIT - 1);
            default:   wait_load = {CW{1'b0}};
        endcase
    endfunction

    function automatic logic is_write(input logic [3:0] st);
        case (st)
            ST_W_RST0, ST_W_RST1, ST_W_CKE, ST_W_PREA, ST_W_ZQCL, ST_W_FIN: is_write = 1'b1;
            default: is_write = 1'b0;
        endcase
    endfunction

    // Command writes target the override register 0x0004; everything else goes to 0x0000.
    function automatic logic [15:0] cmd_addr(input logic [3:0] st);
        case (st)
            ST_W_PREA, ST_W_ZQCL: cmd_addr = 16'h0004;
            default:              cmd_addr = 16'h0000;
        endcase
    endfunction

    function automatic logic [31:0] cmd_data(input logic [3:0] st);
        case (st)
            ST_W_RST0: cmd_data = 32'h0000_0000;
            ST_W_RST1: cmd_data = 32'h0000_0003;
            ST_W_CKE:  cmd_data = 32'h0000_0023;
            ST_W_PREA: cmd_data = 32'h0000_0012;
            ST_W_ZQCL: cmd_data = 32'h0000_0016;
            ST_W_FIN:  cmd_data = FINAL_STATE;
            default:   cmd_data = 32'h0000_0000;
        endcase
    endfunction

    logic [3:0]    state_r;
    logic [3:0]    state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          accept_s;

    assign accept_s       = ctrl_cmd_valid & ctrl_cmd_ack;
    assign ctrl_cmd_write = 1'b1;
    assign step_o         = state_r;

    // Next-state and wait-counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_s = ST_W_RST0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_W_RST0, ST_W_RST1, ST_W_CKE, ST_W_PREA, ST_W_ZQCL: begin
                if (accept_s) begin
                    state_s = state_r + 4'd1;
                    cnt_s   = wait_load(state_r);
                end else begin
                    state_s = state_r;
                end
            end
            ST_W_FIN: begin
                if (accept_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_WAIT_RST, ST_WAIT_CKE, ST_WAIT_XPR, ST_WAIT_RP, ST_WAIT_ZQ: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = state_r + 4'd1;
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered bus/status outputs, all derived from the next state.
    always_ff @(posedge cpu_clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_r          <= ST_IDLE;
            cnt_r            <= {CW{1'b0}};
            ctrl_cmd_valid   <= 1'b0;
            ctrl_cmd_address <= 16'h0000;
            ctrl_cmd_data    <= 32'h0000_0000;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            ctrl_cmd_valid <= is_write(state_s);
            if (is_write(state_s)) begin
                ctrl_cmd_address <= cmd_addr(state_s);
                ctrl_cmd_data    <= cmd_data(state_s);
            end else begin
                ctrl_cmd_address <= ctrl_cmd_address;
                ctrl_cmd_data    <= ctrl_cmd_data;
            end
            busy_o <= (state_s != ST_IDLE) && (state_s != ST_DONE);
            done_o <= (state_s == ST_DONE);
        end
    end

endmodule
